// File: rtl/matvec_result_serializer.sv
// -----------------------------------------------------------------------------
// matvec_result_serializer
//
// Purpose:
//   Downstream stage of the pipelined matrix-vector multiplier. Each packed
//   result word (m_rows row sums) is captured into a small word FIFO. The row
//   sums are then emitted one per beat, row 0 first, on a valid/ready stream.
//   Each beat carries its row index and a last-row flag. This lets the
//   free-running multiplier feed a narrow or stalling consumer.
//
// Optional feature (macro MATVEC_SER_PARITY_EN):
//   When defined, the output out_parity is added. It is the XOR-reduce of
//   out_data and is 0 while no beat is presented.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_data    in   packed result word; row r at [r*elem_width +: elem_width]
//   in_valid   in   in_data valid
//   in_ready   out  word accepted when in_valid && in_ready (0 during rst)
//   out_data   out  current row sum of the head word
//   out_row    out  row index of out_data
//   out_last   out  high on the row m_rows-1 beat
//   out_valid  out  out_data valid (FIFO not empty)
//   out_ready  in   beat consumed when out_valid && out_ready
//   out_parity out  (MATVEC_SER_PARITY_EN only) XOR-reduce of out_data
// -----------------------------------------------------------------------------
module matvec_result_serializer #(
  parameter  int data_width = 3,
  parameter  int n_columns  = 3,
  parameter  int m_rows     = 3,
  parameter  int fifo_depth = 2,
  localparam int elem_width = 2*data_width + $clog2(n_columns),
  localparam int word_width = elem_width*m_rows,
  localparam int row_w      = (m_rows > 1) ? $clog2(m_rows) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [elem_width-1:0] out_data,
  output logic [row_w-1:0]      out_row,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MATVEC_SER_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [row_w-1:0] last_row = row_w'(m_rows - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(fifo_depth);

  // Word storage. Writes are registered; the head word is read
  // combinationally so that a pushed word is visible one cycle later.
  logic [word_width-1:0] mem_q [fifo_depth];

  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0] count_q,  count_d;
  logic [row_w-1:0] row_q,    row_d;

  logic empty;
  logic full;
  logic push;
  logic beat;
  logic pop;
  logic is_last_row;

  logic [word_width-1:0] head_word;
  logic [elem_width-1:0] head_fields [m_rows];

  assign empty       = (count_q == '0);
  assign full        = (count_q == full_cnt);
  assign is_last_row = (row_q == last_row);

  // Readiness is derived from the registered count only: a pop in the
  // same cycle never frees a slot for a simultaneous push.
  assign in_ready  = !rst && !full;
  assign out_valid = !rst && !empty;

  assign push = in_valid && in_ready;
  assign beat = out_valid && out_ready;
  // The head word leaves the FIFO together with its last row.
  assign pop  = beat && is_last_row;

  assign head_word = mem_q[rd_ptr_q];

  // Split the head word into its row fields.
  generate
    for (genvar gi = 0; gi < m_rows; gi++) begin : g_field
      assign head_fields[gi] = head_word[gi*elem_width +: elem_width];
    end
  endgenerate

  // Outputs are forced to zero when no beat is presented, so reset and
  // empty states show a clean, stable bus.
  assign out_data = out_valid ? head_fields[row_q] : '0;
  assign out_row  = row_q;
  assign out_last = out_valid && is_last_row;

`ifdef MATVEC_SER_PARITY_EN
  assign out_parity = ^out_data;
`endif

  // Next-state logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    row_d    = row_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
    end

    if (beat) begin
      row_d = pop ? '0 : row_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      row_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      row_q    <= row_d;
    end
  end

  // Word storage needs no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_matvec_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_matvec_result_serializer
//
// Self-checking bench for matvec_result_serializer. Expected row beats are
// pushed to a scoreboard queue when a word is accepted. They are popped and
// compared whenever the DUT completes a beat. Directed checks cover the
// reset state, backpressure, the no-bubble behaviour and a reset in the
// middle of a word.
// -----------------------------------------------------------------------------
module tb_matvec_result_serializer;

  localparam int DW = 3;
  localparam int NC = 3;
  localparam int MR = 3;
  localparam int FD = 2;
  localparam int EW = 2*DW + $clog2(NC);
  localparam int WW = EW*MR;
  localparam int RW = (MR > 1) ? $clog2(MR) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
`ifdef MATVEC_SER_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  matvec_result_serializer #(
    .data_width (DW),
    .n_columns  (NC),
    .m_rows     (MR),
    .fifo_depth (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MATVEC_SER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  typedef struct packed {
    logic [EW-1:0] d;
    logic [RW-1:0] r;
    logic          l;
  } beat_t;

  beat_t sb_q[$];
  beat_t exp_beat;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Offer one word and wait (bounded) until it is accepted. The expected
  // beats are queued before the accepting edge.
  task automatic push_word(input logic [WW-1:0] w);
    logic done;
    done     = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int r = 0; r < MR; r++) begin
          sb_q.push_back('{d: w[r*EW +: EW], r: RW'(r), l: (r == MR-1)});
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_val("push_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: compare every completed beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_beat = sb_q.pop_front();
        check_val("beat_data", 32'(out_data), 32'(exp_beat.d));
        check_val("beat_row",  32'(out_row),  32'(exp_beat.r));
        check_val("beat_last", 32'(out_last), 32'(exp_beat.l));
`ifdef MATVEC_SER_PARITY_EN
        check_val("beat_parity", 32'(out_parity), 32'(^exp_beat.d));
`endif
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready",  32'(in_ready),  32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready",  32'(in_ready),  32'd1);
    check_val("post_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("post_rst_out_row",   32'(out_row),   32'd0);
    check_val("post_rst_out_last",  32'(out_last),  32'd0);
    check_val("post_rst_out_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1;

    // ---------------- single word, 1-cycle latency ----------------
    out_ready = 1'b1;
    push_word(24'h931405);
    @(negedge clk);
    check_val("t1_first_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t1_idle_after", 32'(out_valid), 32'd0);
    check_val("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // ---------------- backpressure fills the FIFO ----------------
    out_ready = 1'b0;
    push_word(24'h010203);
    push_word(24'h040506);
    @(negedge clk);
    check_val("t2_full_in_ready", 32'(in_ready), 32'd0);
    check_val("t2_hold_data",     32'(out_data), 32'd3);
    check_val("t2_hold_row",      32'(out_row),  32'd0);
    @(posedge clk);
    #1;
    in_data  = 24'h0A0B0C;  // held but must not be taken
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("t2_stall_in_ready", 32'(in_ready), 32'd0);
      check_val("t2_stall_data",     32'(out_data), 32'd3);
      check_val("t2_stall_row",      32'(out_row),  32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_val("t2_stream_valid", 32'(out_valid), (k < 6) ? 32'd1 : 32'd0);
      if (k == 2) check_val("t2_ready_before_pop", 32'(in_ready), 32'd0);
      if (k == 3) check_val("t2_ready_after_pop",  32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end

    // ---------------- push every 3 cycles ----------------
    for (int i = 0; i < 6; i++) begin
      push_word(WW'($urandom));
      check_val("t3_fifo_le1", 32'(sb_q.size() <= MR), 32'd1);
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check_val("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---------------- reset in the middle of a word ----------------
    push_word(24'hFFAA55);
    repeat (2) @(posedge clk);  // rows 0 and 1 consumed
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("t4_rst_in_ready", 32'(in_ready), 32'd0);
    check_val("t4_rst_out_data", 32'(out_data), 32'd0);
    check_val("t4_unsent_rows",  32'(sb_q.size()), 32'd1);
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_val("t4_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("t4_after_valid", 32'(out_valid), 32'd0);
    check_val("t4_after_row",   32'(out_row),   32'd0);
    @(posedge clk);
    #1;
    push_word(24'h000001);
    @(negedge clk);
    check_val("t4_new_row0_data", 32'(out_data), 32'd1);
    check_val("t4_new_row0_row",  32'(out_row),  32'd0);
    @(posedge clk);
    #1;

    // ---------------- parity pattern word ----------------
    push_word(24'h070301);

    // ---------------- drain ----------------
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check_val("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
